gpr_ctrl: RTL and testbench

Sequencing controller for the 4 × 8-bit bit-serial general-purpose register file. It accepts one register-transfer command at a time over a valid/ready handshake and drives the file's shift, write and address controls plus its serial data input. Commands are LDI, MOV, ADD and SUB; arithmetic is done LSB-first with a 1-bit serial ALU. The register file has a single address port, so two-operand commands use two passes: source fetch into an internal buffer, then destination write-back.

---
 rtl/gpr_ctrl_if.sv | 43 ++++
 rtl/gpr_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gpr_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_ctrl_if
//  Description : Bundle between a command source / bit-serial register file
//                and the gpr_ctrl sequencer.
//                slave  - the controller (gpr_ctrl) side
//                master - the environment side (command source + reg file)
//  Ports       : i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_rd/i_cmd_rs/i_cmd_imm
//                command handshake; o_done/o_carry status; o_con_shift,
//                o_con_write, o_rd_addr, o_data_in, i_data_out register-file
//                serial port.
//  Revision    : 1.0  initial release
// ============================================================================
interface gpr_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_op;
    logic [1:0]       i_cmd_rd;
    logic [1:0]       i_cmd_rs;
    logic [WIDTH-1:0] i_cmd_imm;
    logic             o_done;
    logic             o_carry;
    logic             o_con_shift;
    logic             o_con_write;
    logic [1:0]       o_rd_addr;
    logic             o_data_in;
    logic             i_data_out;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_rd, i_cmd_rs, i_cmd_imm, i_data_out,
        output o_cmd_ready, o_done, o_carry, o_con_shift, o_con_write,
               o_rd_addr, o_data_in
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_rd, i_cmd_rs, i_cmd_imm, i_data_out,
        input  o_cmd_ready, o_done, o_carry, o_con_shift, o_con_write,
               o_rd_addr, o_data_in
    );
endinterface
`default_nettype wire

// File: rtl/gpr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_ctrl
//  Description : Sequencer for a 4 x WIDTH bit-serial register file.
//                Executes LDI / MOV / ADD / SUB one at a time. Two-operand
//                commands first rotate the source register into an internal
//                buffer (FETCH), then rewrite the destination LSB-first
//                through a 1-bit serial ALU (EXEC).
//  Ports       : i_clk    - clock, rising edge
//                i_rst_n  - synchronous active-low reset
//                bus      - gpr_ctrl_if.slave: command handshake, status,
//                           register-file shift/write/address/serial data
//  Revision    : 1.0  initial release
// ============================================================================
module gpr_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    gpr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_op_ldi   = 2'b00;
    localparam logic [1:0] c_op_sub   = 2'b11;
    localparam logic [2:0] c_cnt_last = 3'(WIDTH - 1);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_buf;
    logic             r_cy;
    logic [1:0]       r_op;
    logic [1:0]       r_rd;
    logic [1:0]       r_rs;

    logic             r_ready;
    logic             r_done;
    logic             r_carry;
    logic             r_shift;
    logic             r_write;
    logic [1:0]       r_addr;

    // Serial ALU: a is the destination bit streaming out of the file,
    // b is the buffered source bit (inverted for SUB, with cy preset to 1).
    logic w_a;
    logic w_b;
    logic w_arith;
    logic w_sum;
    logic w_cy_next;
    logic w_data_in;

    assign w_arith   = r_op[1];
    assign w_a       = bus.i_data_out;
    assign w_b       = (r_op == c_op_sub) ? ~r_buf[0] : r_buf[0];
    assign w_sum     = w_a ^ w_b ^ r_cy;
    assign w_cy_next = (w_a & w_b) | (w_a & r_cy) | (w_b & r_cy);

    always_comb begin
        w_data_in = 1'b0;
        if (r_state == S_EXEC) begin
            w_data_in = w_arith ? w_sum : r_buf[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_buf   <= '0;
            r_cy    <= 1'b0;
            r_op    <= 2'd0;
            r_rd    <= 2'd0;
            r_rs    <= 2'd0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_carry <= 1'b0;
            r_shift <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_ready is high throughout IDLE, so valid alone accepts
                    if (bus.i_cmd_valid) begin
                        r_op    <= bus.i_cmd_op;
                        r_rd    <= bus.i_cmd_rd;
                        r_rs    <= bus.i_cmd_rs;
                        r_cnt   <= 3'd0;
                        r_ready <= 1'b0;
                        r_shift <= 1'b1;
                        if (bus.i_cmd_op == c_op_ldi) begin
                            r_buf   <= bus.i_cmd_imm;
                            r_write <= 1'b1;
                            r_addr  <= bus.i_cmd_rd;
                            r_state <= S_EXEC;
                        end else begin
                            r_write <= 1'b0;
                            r_addr  <= bus.i_cmd_rs;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    // Source rotates a full turn; its bits collect MSB-down
                    // so buf[0] ends up holding the source LSB.
                    r_buf  <= {bus.i_data_out, r_buf[WIDTH-1:1]};
                    r_addr <= r_rs;
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= 3'd0;
                        r_cy    <= (r_op == c_op_sub);
                        r_write <= 1'b1;
                        r_addr  <= r_rd;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                S_EXEC: begin
                    r_buf <= {1'b0, r_buf[WIDTH-1:1]};
                    if (w_arith) begin
                        r_cy <= w_cy_next;
                    end
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= 3'd0;
                        r_shift <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        if (w_arith) begin
                            r_carry <= w_cy_next;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready = r_ready;
    assign bus.o_done      = r_done;
    assign bus.o_carry     = r_carry;
    assign bus.o_con_shift = r_shift;
    assign bus.o_con_write = r_write;
    assign bus.o_rd_addr   = r_addr;
    assign bus.o_data_in   = w_data_in;

endmodule
`default_nettype wire

// File: tb/tb_gpr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_ctrl
//  Description : Directed bench for gpr_ctrl with a behavioural 4 x 8
//                bit-serial register file attached to its serial port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpr_ctrl;

    localparam int WIDTH = 8;
    localparam logic [1:0] c_ldi = 2'b00;
    localparam logic [1:0] c_mov = 2'b01;
    localparam logic [1:0] c_add = 2'b10;
    localparam logic [1:0] c_sub = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gpr_ctrl_if #(.WIDTH(WIDTH)) bus ();

    gpr_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register file: addressed register rotates right when shifting, taking
    // data_in as new MSB when writing, else its own LSB.
    logic [7:0] rf [4] = '{default: 8'h00};
    assign bus.i_data_out = rf[bus.o_rd_addr][0];
    always @(posedge clk) begin
        if (bus.o_con_shift) begin
            rf[bus.o_rd_addr] <= {(bus.o_con_write ? bus.o_data_in : rf[bus.o_rd_addr][0]),
                                  rf[bus.o_rd_addr][7:1]};
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_rf [4] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("%s_r%0d", tag, r), {24'd0, rf[r]}, {24'd0, exp_rf[r]});
        end
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [7:0] imm);
        bus.i_cmd_op  = op;
        bus.i_cmd_rd  = rd;
        bus.i_cmd_rs  = rs;
        bus.i_cmd_imm = imm;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.o_cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", {31'd0, bus.o_cmd_ready}, 32'd1);
    endtask

    // Issue one command; lat = cycle index (after handshake) in which done shows.
    task automatic send(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm, output int lat);
        @(negedge clk);
        set_cmd(op, rd, rs, imm);
        bus.i_cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        chk("ready_low_cycle1", {31'd0, bus.o_cmd_ready}, 32'd0);
        lat = 1;
        while (!bus.o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        chk("done_single_pulse", {31'd0, bus.o_done}, 32'd0);
        chk("ready_after_done", {31'd0, bus.o_cmd_ready}, 32'd1);
    endtask

    // Two commands with valid held; gap = cycles from first to second accept.
    task automatic held_pair(input logic [1:0] op1, input logic [1:0] rd1, input logic [1:0] rs1,
                             input logic [7:0] imm1,
                             input logic [1:0] op2, input logic [1:0] rd2, input logic [1:0] rs2,
                             input logic [7:0] imm2, input int gap);
        int k;
        int first_ready;
        int dones;
        int lat;
        @(negedge clk);
        set_cmd(op1, rd1, rs1, imm1);
        bus.i_cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        set_cmd(op2, rd2, rs2, imm2);
        first_ready = 0;
        dones = 0;
        k = 1;
        while (k < 40 && first_ready == 0) begin
            if (bus.o_done) dones++;
            if (bus.o_cmd_ready) begin
                first_ready = k;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        chk("held_accept_gap", first_ready, gap);
        chk("held_done_count", dones, 32'd1);
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        chk("held_second_busy", {31'd0, bus.o_cmd_ready}, 32'd0);
        lat = 1;
        while (!bus.o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_second_latency", lat, gap - 1);
        @(posedge clk);
        #1;
        chk("held_ready_back", {31'd0, bus.o_cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic [7:0] exp_val;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int lat;

        bus.i_cmd_valid = 1'b0;
        set_cmd(2'd0, 2'd0, 2'd0, 8'h00);

        vecs[0]  = '{c_ldi, 2'd1, 2'd0, 8'hA5, 8'hA5, 1'b0};
        vecs[1]  = '{c_mov, 2'd0, 2'd1, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{c_ldi, 2'd2, 2'd0, 8'hF0, 8'hF0, 1'b0};
        vecs[3]  = '{c_ldi, 2'd3, 2'd0, 8'h20, 8'h20, 1'b0};
        vecs[4]  = '{c_add, 2'd2, 2'd3, 8'h00, 8'h10, 1'b1};
        vecs[5]  = '{c_ldi, 2'd1, 2'd0, 8'h05, 8'h05, 1'b1};
        vecs[6]  = '{c_ldi, 2'd0, 2'd0, 8'h07, 8'h07, 1'b1};
        vecs[7]  = '{c_sub, 2'd1, 2'd0, 8'h00, 8'hFE, 1'b0};
        vecs[8]  = '{c_ldi, 2'd1, 2'd0, 8'h07, 8'h07, 1'b0};
        vecs[9]  = '{c_sub, 2'd1, 2'd0, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{c_ldi, 2'd1, 2'd0, 8'h81, 8'h81, 1'b1};
        vecs[11] = '{c_add, 2'd1, 2'd1, 8'h00, 8'h02, 1'b1};
        vecs[12] = '{c_mov, 2'd2, 2'd1, 8'h00, 8'h02, 1'b1};
        vecs[13] = '{c_add, 2'd0, 2'd0, 8'h00, 8'h0E, 1'b0};
        vecs[14] = '{c_mov, 2'd1, 2'd0, 8'h00, 8'h0E, 1'b0};
        vecs[15] = '{c_sub, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
        chk("rst_done",  {31'd0, bus.o_done},      32'd0);
        chk("rst_carry", {31'd0, bus.o_carry},     32'd0);
        chk("rst_shift", {31'd0, bus.o_con_shift}, 32'd0);
        chk("rst_write", {31'd0, bus.o_con_write}, 32'd0);
        chk("rst_addr",  {30'd0, bus.o_rd_addr},   32'd0);
        chk("rst_din",   {31'd0, bus.o_data_in},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven commands
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, lat);
            exp_rf[vecs[i].rd] = vecs[i].exp_val;
            chk($sformatf("v%0d_latency", i), lat, (vecs[i].op == c_ldi) ? 32'd9 : 32'd17);
            chk($sformatf("v%0d_carry", i), {31'd0, bus.o_carry}, {31'd0, vecs[i].exp_carry});
            chk_regs($sformatf("v%0d", i));
        end

        // Back-to-back LDIs with valid held
        held_pair(c_ldi, 2'd0, 2'd0, 8'h11, c_ldi, 2'd1, 2'd0, 8'h22, 10);
        exp_rf[0] = 8'h11;
        exp_rf[1] = 8'h22;
        chk_regs("held_ldi");
        chk("held_ldi_carry", {31'd0, bus.o_carry}, 32'd1);

        // MOV then ADD with valid held: r2=r0=0x11, r3=0x00+0x22
        held_pair(c_mov, 2'd2, 2'd0, 8'h00, c_add, 2'd3, 2'd1, 8'h00, 18);
        exp_rf[2] = 8'h11;
        exp_rf[3] = 8'h22;
        chk_regs("held_mov_add");
        chk("held_add_carry", {31'd0, bus.o_carry}, 32'd0);

        // Set carry, then abort an ADD in EXEC cycle 4 with reset
        send(c_ldi, 2'd2, 2'd0, 8'hF0, lat);
        send(c_add, 2'd2, 2'd2, 8'h00, lat);
        exp_rf[2] = 8'hE0;
        chk("pre_abort_carry", {31'd0, bus.o_carry}, 32'd1);
        chk_regs("pre_abort");

        @(negedge clk);
        set_cmd(c_add, 2'd2, 2'd3, 8'h00);
        bus.i_cmd_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.i_cmd_valid = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        chk("abort_in_exec_shift", {31'd0, bus.o_con_shift}, 32'd1);
        chk("abort_in_exec_write", {31'd0, bus.o_con_write}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
        chk("abort_shift", {31'd0, bus.o_con_shift}, 32'd0);
        chk("abort_write", {31'd0, bus.o_con_write}, 32'd0);
        chk("abort_carry", {31'd0, bus.o_carry},     32'd0);
        chk("abort_done",  {31'd0, bus.o_done},      32'd0);
        chk("abort_r0", {24'd0, rf[0]}, {24'd0, exp_rf[0]});
        chk("abort_r1", {24'd0, rf[1]}, {24'd0, exp_rf[1]});
        chk("abort_r3", {24'd0, rf[3]}, {24'd0, exp_rf[3]});
        @(negedge clk);
        rst_n = 1'b1;

        // Controller usable again after abort
        send(c_ldi, 2'd2, 2'd0, 8'h5A, lat);
        exp_rf[2] = 8'h5A;
        chk("post_abort_latency", lat, 32'd9);
        chk_regs("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
